mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, the data width (matches the 32-bit memory cell).
REQ-003 The block SHALL have parameter MEM_LATENCY, default 1, the cycles from mem_re high to valid mem_rdata; legal range 1..15.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have ports p0_req / p1_req, input, 1 bit each: the requester asks for one memory access.
REQ-007 The block SHALL have ports p0_we / p1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-008 The block SHALL have ports p0_addr / p1_addr, input, ADDR_W bits each: the access address.
REQ-009 The block SHALL have ports p0_wdata / p1_wdata, input, DATA_W bits each: the write data.
REQ-010 The block SHALL have ports p0_gnt / p1_gnt, output, 1 bit each: one-cycle pulse, command accepted.
REQ-011 The block SHALL have ports p0_done / p1_done, output, 1 bit each: one-cycle pulse, access complete.
REQ-012 The block SHALL have ports p0_rdata / p1_rdata, output, DATA_W bits each: read result, valid while the matching pN_done is high.
REQ-013 The block SHALL have ports mem_we, mem_re, output, 1 bit each: the memory strobes.
REQ-014 The block SHALL have port mem_addr, output, ADDR_W bits: the memory address.
REQ-015 The block SHALL have port mem_wdata, output, DATA_W bits: the memory write data.
REQ-016 The block SHALL have port mem_rdata, input, DATA_W bits: the memory read data.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-019 In IDLE, if any pN_req is high at edge t, the FSM SHALL latch the winner's we/addr/wdata and go to ISSUE for cycle t+1.
REQ-020 In ISSUE, the block SHALL pulse the winner's pN_gnt and drive mem_addr/mem_wdata from the latch, with exactly one of mem_we or mem_re high, for exactly one cycle.
REQ-021 After a write ISSUE, the FSM SHALL go directly to DONE, so write completion is at t+2.
REQ-022 After a read ISSUE, the FSM SHALL spend exactly MEM_LATENCY cycles in WAIT, counted by a 4-bit counter.
REQ-023 On the last WAIT cycle, the block SHALL capture mem_rdata into the winner's rdata register; read completion is then at t+2+MEM_LATENCY.
REQ-024 In DONE, the block SHALL pulse the winner's pN_done (with pN_rdata valid for reads) and return to IDLE.
REQ-025 The earliest next acceptance SHALL be the IDLE cycle following DONE.
REQ-026 Arbitration SHALL be round-robin using a 1-bit last-served pointer.
REQ-027 If a single requester asserts req, it SHALL win regardless of the pointer.
REQ-028 If both requesters assert req in the same IDLE cycle, the requester that was not last served SHALL win, and the pointer SHALL update at grant.
REQ-029 Requesters SHALL hold req and command stable until gnt; the block SHALL sample them only in IDLE.
REQ-030 Requests arriving while the block is not in IDLE SHALL be ignored until IDLE; they are not queued.
REQ-031 A requester deasserting req before gnt SHALL cause no access.
REQ-032 mem_we and mem_re SHALL never be high together, and both SHALL be low outside ISSUE.
REQ-033 pN_rdata SHALL hold its last captured value until the next read completes for that port.
REQ-034 Exactly one gnt and exactly one done SHALL be produced per accepted access, to the same port.

Reset
REQ-035 While rst is high, the block SHALL hold state IDLE, the pointer SHALL be 1 (so p0 wins first contention), and the counter, all gnt/done/strobes, mem_addr, mem_wdata and both rdata registers SHALL be 0.
REQ-036 Reset mid-access SHALL abort immediately with no gnt or done for the aborted access and strobes low in the same cycle.
REQ-037 After rst is released, operation SHALL resume from IDLE on the first clk edge.

Structure
REQ-038 The package mem_arb_pkg SHALL hold the state encoding constants (IDLE, ISSUE, WAIT, DONE) and the port ID constants PORT0 = 0, PORT1 = 1.
REQ-039 The block SHALL instantiate one sub-module, rr_arb2, a combinational 2-way round-robin pick taking (req0, req1, last) and giving (winner, valid).
REQ-040 The rest of the block (FSM, counter, latches) SHALL reside in mem_arbiter.

Verification
REQ-041 A bench SHALL cover: p0 write addr 0x10, data 0xDEADBEEF at t -> p0_gnt at t+1 with mem_we=1, mem_addr=0x10; p0_done at t+2; no p1 pulses.
REQ-042 A bench SHALL cover: p1 read addr 0x10, MEM_LATENCY=1 -> mem_re at t+1; p1_done at t+3 with p1_rdata=0xDEADBEEF.
REQ-043 A bench SHALL cover: both req from reset -> p0 granted first, then p1 at the next IDLE; with both held continuously, grants alternate 0,1,0,1.
REQ-044 A bench SHALL cover: MEM_LATENCY=3 read -> exactly 3 WAIT cycles; done at t+5; mem_re high exactly 1 cycle.
REQ-045 A bench SHALL cover: rst asserted during WAIT -> strobes/done 0 at once; no done ever for that access; a new p1 read after release completes normally.
REQ-046 A bench SHALL cover: p1 req raised during a p0 WAIT -> ignored until IDLE, then granted; assertion that mem_we&mem_re is never 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and port IDs.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; a lone requester always wins, contention goes to
// whichever port was not served last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            winner = (last == PORT0) ? PORT1 : PORT0;
        end else begin
            winner = req1 ? PORT1 : PORT0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-outstanding memory arbiter: round-robin accept in IDLE,
// one-cycle command issue, fixed-latency read wait, one-cycle completion.
//
//   state | meaning
//   IDLE  | sample requests, latch the winner's command
//   ISSUE | gnt pulse and one memory strobe
//   WAIT  | read in flight, MEM_LATENCY cycles
//   DONE  | done pulse, rdata valid for reads
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Down-counter starts at latency-1 so terminal count 0 marks the last WAIT cycle.
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              arb_winner;
    logic              arb_valid;
    logic              sel_we;

    rr_arb2 u_rr_arb2 (
        .req0   (p0_req),
        .req1   (p1_req),
        .last   (last_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    assign sel_we = (arb_winner == PORT1) ? p1_we : p0_we;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        port_d      = port_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        gnt_d       = 2'b00;
        done_d      = 2'b00;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d            = ISSUE;
                    port_d             = arb_winner;
                    last_d             = arb_winner;
                    we_d               = sel_we;
                    gnt_d[arb_winner]  = 1'b1;
                    mem_we_d           = sel_we;
                    mem_re_d           = ~sel_we;
                    mem_addr_d         = (arb_winner == PORT1) ? p1_addr  : p0_addr;
                    mem_wdata_d        = (arb_winner == PORT1) ? p1_wdata : p0_wdata;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d        = DONE;
                    done_d[port_q] = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d        = DONE;
                    done_d[port_q] = 1'b1;
                    if (port_q == PORT1) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= PORT1;
            port_q      <= PORT0;
            we_q        <= 1'b0;
            cnt_q       <= 4'd0;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            port_q      <= port_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign p0_gnt    = gnt_q[PORT0];
    assign p1_gnt    = gnt_q[PORT1];
    assign p0_done   = done_q[PORT0];
    assign p1_done   = done_q[PORT1];
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a latency-1 instance with a full monitor
// and a latency-3 instance exercised directly for read timing.
module tb_mem_arbiter;

    localparam logic [31:0] GARBAGE = 32'h0BAD_F00D;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // latency-1 instance
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_done, p1_gnt, p1_done;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // latency-3 instance (only port 0 used)
    logic        q_req, q_we;
    logic [31:0] q_addr, q_wdata;
    logic        q_gnt, q_done, q1_gnt, q1_done;
    logic [31:0] q_rdata, q1_rdata;
    logic        q_mem_we, q_mem_re;
    logic [31:0] q_mem_addr, q_mem_wdata, q_mem_rdata;
    logic        q1_req, q1_we;
    logic [31:0] q1_addr, q1_wdata;

    exp_t        exp_q[$];
    logic [31:0] mem_a[logic [31:0]];
    logic [31:0] mem_b[logic [31:0]];
    logic        a_pend = 1'b0, b_pend = 1'b0;
    int          a_cnt = 0, b_cnt = 0;
    logic [31:0] a_addr = '0, b_addr = '0;
    logic        gnt_seen = 1'b0;
    int          gnt_at = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .p0_req(q_req), .p0_we(q_we), .p0_addr(q_addr), .p0_wdata(q_wdata),
        .p0_gnt(q_gnt), .p0_done(q_done), .p0_rdata(q_rdata),
        .p1_req(q1_req), .p1_we(q1_we), .p1_addr(q1_addr), .p1_wdata(q1_wdata),
        .p1_gnt(q1_gnt), .p1_done(q1_done), .p1_rdata(q1_rdata),
        .mem_we(q_mem_we), .mem_re(q_mem_re), .mem_addr(q_mem_addr),
        .mem_wdata(q_mem_wdata), .mem_rdata(q_mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory models: data is valid only in the cycle the latency says, garbage otherwise.
    initial begin
        mem_rdata = GARBAGE;
        forever begin
            @(negedge clk);
            if (rst) a_pend = 1'b0;
            if (a_pend) a_cnt--;
            if (mem_we) mem_a[mem_addr] = mem_wdata;
            if (mem_re) begin a_pend = 1'b1; a_cnt = 1; a_addr = mem_addr; end
            if (a_pend && a_cnt == 0) begin
                mem_rdata = mem_a.exists(a_addr) ? mem_a[a_addr] : 32'h0;
                a_pend = 1'b0;
            end else begin
                mem_rdata = GARBAGE;
            end
        end
    end

    initial begin
        q_mem_rdata = GARBAGE;
        forever begin
            @(negedge clk);
            if (rst) b_pend = 1'b0;
            if (b_pend) b_cnt--;
            if (q_mem_we) mem_b[q_mem_addr] = q_mem_wdata;
            if (q_mem_re) begin b_pend = 1'b1; b_cnt = 3; b_addr = q_mem_addr; end
            if (b_pend && b_cnt == 0) begin
                q_mem_rdata = mem_b.exists(b_addr) ? mem_b[b_addr] : 32'h0;
                b_pend = 1'b0;
            end else begin
                q_mem_rdata = GARBAGE;
            end
        end
    end

    always @(negedge clk) begin
        assert (!(mem_we && mem_re));
        assert (!(q_mem_we && q_mem_re));
    end

    // Scoreboard monitor for the latency-1 instance.
    always @(negedge clk) begin
        exp_t cur;
        if (rst) begin
            gnt_seen = 1'b0;
        end else begin
            check("we_re_excl", {63'b0, mem_we & mem_re}, 64'd0);
            check("strobe_only_with_gnt", {63'b0, mem_we | mem_re}, {63'b0, p0_gnt | p1_gnt});
            if (p0_gnt && p1_gnt) check("gnt_onehot", 64'd1, 64'd0);
            if (p0_gnt || p1_gnt) begin
                if (exp_q.size() == 0 || gnt_seen) begin
                    check("unexpected_gnt", {63'b0, p1_gnt}, 64'hFF);
                end else begin
                    cur      = exp_q[0];
                    gnt_seen = 1'b1;
                    gnt_at   = cyc;
                    check("gnt_port", {63'b0, p1_gnt}, {63'b0, cur.port});
                    check("gnt_cyc", 64'(cyc), 64'(cur.gnt_cyc));
                    check("mem_we", {63'b0, mem_we}, {63'b0, cur.we});
                    check("mem_re", {63'b0, mem_re}, {63'b0, ~cur.we});
                    check("mem_addr", {32'b0, mem_addr}, {32'b0, cur.addr});
                    if (cur.we) check("mem_wdata", {32'b0, mem_wdata}, {32'b0, cur.wdata});
                end
            end
            if (p0_done || p1_done) begin
                if (!gnt_seen) begin
                    check("unexpected_done", {63'b0, p1_done}, 64'hFF);
                end else begin
                    cur      = exp_q.pop_front();
                    gnt_seen = 1'b0;
                    check("done_port", {63'b0, p1_done}, {63'b0, cur.port});
                    check("done_cyc", 64'(cyc), 64'(gnt_at + (cur.we ? 1 : 2)));
                    if (!cur.we)
                        check("rdata", {32'b0, cur.port ? p1_rdata : p0_rdata}, {32'b0, cur.rdata});
                end
            end
        end
    end

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic push(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int gc);
        exp_t e;
        e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.gnt_cyc = gc;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (p0_done || p1_done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) check(tag, 64'd0, 64'd1);
    endtask

    task automatic single(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata);
        logic ok = 1'b0;
        @(negedge clk);
        drive(port, 1'b1, we, addr, wdata);
        push(port, we, addr, wdata, rdata, cyc + 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (port ? p1_gnt : p0_gnt) begin ok = 1'b1; break; end
        end
        drive(port, 1'b0, 1'b0, '0, '0);
        if (!ok) check("gnt_timeout", 64'd0, 64'd1);
        else wait_done("done_timeout");
    endtask

    task automatic run3(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata_exp);
        int t, g_at, d_at, re_cnt, we_cnt, re_at;
        logic [31:0] rd;
        @(negedge clk);
        q_req = 1'b1; q_we = we; q_addr = addr; q_wdata = wdata;
        t = cyc + 1; g_at = -1; d_at = -1; re_cnt = 0; we_cnt = 0; re_at = -1; rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (q_gnt) begin g_at = cyc; q_req = 1'b0; end
            if (q_mem_re) begin re_cnt++; re_at = cyc; end
            if (q_mem_we) we_cnt++;
            if (q_done && d_at < 0) begin d_at = cyc; rd = q_rdata; end
        end
        check("l3_gnt_cyc", 64'(g_at), 64'(t));
        check("l3_done_cyc", 64'(d_at), 64'(we ? t + 1 : t + 4));
        check("l3_re_cnt", 64'(re_cnt), we ? 64'd0 : 64'd1);
        check("l3_we_cnt", 64'(we_cnt), we ? 64'd1 : 64'd0);
        if (!we) begin
            check("l3_re_cyc", 64'(re_at), 64'(t));
            check("l3_rdata", {32'b0, rd}, {32'b0, rdata_exp});
        end
    endtask

    initial begin
        int t0, n0, n1, dones;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        q_req = 1'b0; q_we = 1'b0; q_addr = '0; q_wdata = '0;
        q1_req = 1'b0; q1_we = 1'b0; q1_addr = '0; q1_wdata = '0;
        repeat (3) @(negedge clk);

        check("rst_gnt", {60'b0, p0_gnt, p1_gnt, q_gnt, q1_gnt}, 64'd0);
        check("rst_done", {60'b0, p0_done, p1_done, q_done, q1_done}, 64'd0);
        check("rst_strobes", {60'b0, mem_we, mem_re, q_mem_we, q_mem_re}, 64'd0);
        check("rst_mem_addr", {32'b0, mem_addr}, 64'd0);
        check("rst_mem_wdata", {32'b0, mem_wdata}, 64'd0);
        check("rst_rdata", {p0_rdata, p1_rdata}, 64'd0);

        rst = 1'b0;

        // p0 write then p1 read back at latency 1
        single(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0);
        single(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
        check("p0_rdata_untouched", {32'b0, p0_rdata}, 64'd0);

        // contention straight from reset: p0 first, then alternating
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h100, 32'h1111_0000);
        drive(1'b1, 1'b1, 1'b1, 32'h200, 32'h2222_0000);
        t0 = cyc + 1;
        push(1'b0, 1'b1, 32'h100, 32'h1111_0000, '0, t0);
        push(1'b1, 1'b1, 32'h200, 32'h2222_0000, '0, t0 + 3);
        push(1'b0, 1'b1, 32'h104, 32'h1111_0001, '0, t0 + 6);
        push(1'b1, 1'b1, 32'h204, 32'h2222_0001, '0, t0 + 9);
        n0 = 0; n1 = 0; dones = 0;
        for (int i = 0; i < 40 && dones < 4; i++) begin
            @(negedge clk);
            if (p0_done || p1_done) dones++;
            if (p0_gnt) begin
                n0++;
                if (n0 == 1) drive(1'b0, 1'b1, 1'b1, 32'h104, 32'h1111_0001);
                else drive(1'b0, 1'b0, 1'b0, '0, '0);
            end
            if (p1_gnt) begin
                n1++;
                if (n1 == 1) drive(1'b1, 1'b1, 1'b1, 32'h204, 32'h2222_0001);
                else drive(1'b1, 1'b0, 1'b0, '0, '0);
            end
        end
        check("rr_dones", 64'(dones), 64'd4);

        // p1 request during p0 WAIT is held off until IDLE
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h104, '0);
        t0 = cyc + 1;
        push(1'b0, 1'b0, 32'h104, '0, 32'h1111_0001, t0);
        push(1'b1, 1'b0, 32'h100, '0, 32'h1111_0000, t0 + 4);
        dones = 0;
        for (int i = 0; i < 40 && dones < 2; i++) begin
            @(negedge clk);
            if (p0_done || p1_done) dones++;
            if (p0_gnt) drive(1'b0, 1'b0, 1'b0, '0, '0);
            if (p1_gnt) drive(1'b1, 1'b0, 1'b0, '0, '0);
            if (cyc == t0 + 1) drive(1'b1, 1'b1, 1'b0, 32'h100, '0);
        end
        check("late_req_dones", 64'(dones), 64'd2);

        // reset during WAIT aborts the read outright
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h204, '0);
        push(1'b0, 1'b0, 32'h204, '0, 32'h2222_0001, cyc + 1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        check("abort_gnt_seen", {63'b0, p0_gnt}, 64'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_strobes", {62'b0, mem_we, mem_re}, 64'd0);
        check("abort_done", {62'b0, p0_done, p1_done}, 64'd0);
        check("abort_rdata", {p0_rdata, p1_rdata}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (p0_done || p1_done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        single(1'b1, 1'b0, 32'h10, '0, 32'hDEAD_BEEF);

        // request withdrawn before IDLE never becomes an access
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h300, 32'h3333_3333);
        push(1'b0, 1'b1, 32'h300, 32'h3333_3333, '0, cyc + 1);
        @(negedge clk);
        check("wd_p0_gnt", {63'b0, p0_gnt}, 64'd1);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b1, 1'b0, 32'h300, '0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        wait_done("wd_done_timeout");
        n1 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (p1_gnt) n1++;
        end
        check("wd_no_p1_gnt", 64'(n1), 64'd0);
        check("p1_rdata_hold", {32'b0, p1_rdata}, {32'b0, 32'hDEAD_BEEF});
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        // latency-3 instance: write then timed read
        run3(1'b1, 32'h20, 32'hCAFE_F00D, '0);
        run3(1'b0, 32'h20, '0, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
